// File: rtl/core_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch and
// load/store. Data has priority; one access is in flight at a time.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_valid_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  core_stall_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_d_q, owner_d_d;   // 1 = data port owns the access
  logic                  store_q, store_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  d_valid_q, d_valid_d;

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    store_d     = store_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_i) begin
          owner_d_d   = 1'b1;
          store_d     = d_we_i;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          state_d     = ACCESS;
        end else if (if_req_i) begin
          owner_d_d   = 1'b0;
          store_d     = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr_i;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = 3'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // cnt reaches zero in the cycle the memory output is valid
        if (cnt_q == 3'd0) begin
          if (owner_d_q) begin
            d_valid_d = 1'b1;
            if (!store_q) d_rdata_d = mem_rdata_i;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      store_q     <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign if_rdata_o   = if_rdata_q;
  assign d_rdata_o    = d_rdata_q;
  assign if_valid_o   = if_valid_q;
  assign d_valid_o    = d_valid_q;
  assign core_stall_o = (if_req_i & ~if_valid_q) | (d_req_i & ~d_valid_q);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: two instances (latency 1 and 4), each with its own
// fixed-latency memory model; expectations come from a shadow memory and timing rules.
`define CHK(tag, obs, exp) begin vec++; assert ((obs) === (exp)) else begin errs++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

module tb_core_mem_arbiter;
  logic        clk = 1'b0;
  int          cyc = 0;
  int          vec = 0, errs = 0;

  logic        rst_n[2], if_req[2], d_req[2], d_we[2];
  logic [9:0]  if_addr[2], d_addr[2], mem_addr[2];
  logic [31:0] d_wdata[2], if_rdata[2], d_rdata[2], mem_wdata[2], mem_rdata[2];
  logic        if_valid[2], d_valid[2], mem_en[2], mem_we[2], stall[2];

  logic [31:0] mem[2][1024];
  logic [31:0] refm[2][1024];
  logic        dv_q[2][9];
  logic [31:0] dd_q[2][9];

  int en_cnt[2], en_cyc[2], en_prev[2], dv_cnt[2], iv_cnt[2];
  logic [9:0]  en_addr[2];
  logic        en_we[2];
  logic [31:0] en_wd[2];
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    core_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_rdata_o(if_rdata[g]), .if_valid_o(if_valid[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
      .d_rdata_o(d_rdata[g]), .d_valid_o(d_valid[g]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(mem_rdata[g]), .core_stall_o(stall[g]));
    // read data is only meaningful exactly LAT cycles after the enable cycle
    assign mem_rdata[g] = dv_q[g][LAT] ? dd_q[g][LAT] : 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 8; k >= 2; k--) begin
        dv_q[d][k] <= dv_q[d][k-1];
        dd_q[d][k] <= dd_q[d][k-1];
      end
      dv_q[d][1] <= mem_en[d];
      dd_q[d][1] <= mem[d][mem_addr[d]];
      if (mem_en[d] && mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d]) begin
        en_cnt[d]++;
        en_prev[d] = en_cyc[d];
        en_cyc[d]  = cyc;
        en_addr[d] = mem_addr[d];
        en_we[d]   = mem_we[d];
        en_wd[d]   = mem_wdata[d];
      end
      if (mem_we[d] && !mem_en[d]) bad++;
      if (if_valid[d] && d_valid[d]) bad++;
      if (d_valid[d]) dv_cnt[d]++;
      if (if_valid[d]) iv_cnt[d]++;
    end
  end

  task automatic access(input int d, input bit isd, input bit we, input logic [9:0] a,
                        input logic [31:0] wd, input bit b2b);
    int L, t0, en0;
    bit got, v;
    logic [31:0] rd_prev;
    L = (d == 0) ? 1 : 4;
    if (!b2b) @(negedge clk);
    if (isd) begin d_req[d] = 1'b1; d_we[d] = we; d_addr[d] = a; d_wdata[d] = wd; end
    else begin if_req[d] = 1'b1; if_addr[d] = a; end
    t0 = cyc + (b2b ? 1 : 0);
    en0 = en_cnt[d];
    rd_prev = d_rdata[d];
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      v = isd ? d_valid[d] : if_valid[d];
      if (v) begin got = 1'b1; break; end
      `CHK("stall_pending", stall[d], 1'b1)
    end
    `CHK("valid_timeout", got, 1'b1)
    `CHK("valid_latency", cyc - t0, L + 2)
    `CHK("stall_at_valid", stall[d], 1'b0)
    `CHK("en_latency", en_cyc[d] - t0, 1)
    `CHK("en_count", en_cnt[d] - en0, 1)
    `CHK("en_addr", en_addr[d], a)
    `CHK("en_we", en_we[d], isd & we)
    if (isd && we) begin
      `CHK("store_wdata", en_wd[d], wd)
      `CHK("store_rdata_hold", d_rdata[d], rd_prev)
      refm[d][a] = wd;
    end else if (isd) begin
      `CHK("load_data", d_rdata[d], refm[d][a])
    end else begin
      `CHK("fetch_data", if_rdata[d], refm[d][a])
    end
    if (isd) d_req[d] = 1'b0; else if_req[d] = 1'b0;
  endtask

  initial begin
    int t0, td, ti, last, dcnt0, ecnt0;
    bit seen_d;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; if_req[d] = 1'b0; d_req[d] = 1'b0; d_we[d] = 1'b0;
      if_addr[d] = '0; d_addr[d] = '0; d_wdata[d] = '0;
      en_cnt[d] = 0; en_cyc[d] = 0; en_prev[d] = 0; dv_cnt[d] = 0; iv_cnt[d] = 0;
      for (int k = 0; k < 9; k++) begin dv_q[d][k] = 1'b0; dd_q[d][k] = '0; end
      for (int k = 0; k < 1024; k++) begin
        mem[d][k] = $urandom; refm[d][k] = mem[d][k];
      end
      mem[d][4]   = 32'h00500093; refm[d][4]   = 32'h00500093;
      mem[d][256] = 32'hDEADBEEF; refm[d][256] = 32'hDEADBEEF;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      `CHK("reset_outputs", {mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], if_valid[d], d_valid[d],
                             if_rdata[d], d_rdata[d], stall[d]}, 110'd0)
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // first fetch, latency 1
    access(0, 0, 0, 10'h004, 32'h0, 0);

    // simultaneous load and fetch: data wins, fetch follows after one idle cycle
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 10'h100;
    if_req[0] = 1'b1; if_addr[0] = 10'h008;
    t0 = cyc; td = 0; ti = 0; seen_d = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (d_valid[0]) begin
        td = cyc; seen_d = 1'b1;
        `CHK("both_load_data", d_rdata[0], 32'hDEADBEEF)
        `CHK("both_stall_fetch_pending", stall[0], 1'b1)
        d_req[0] = 1'b0;
      end
      if (if_valid[0]) begin ti = cyc; break; end
    end
    if_req[0] = 1'b0;
    `CHK("both_data_first", seen_d && (ti > td), 1'b1)
    `CHK("both_load_latency", td - t0, 3)
    `CHK("both_fetch_after", ti - td, 4)
    `CHK("both_en_spacing", en_cyc[0] - en_prev[0], 4)
    `CHK("both_fetch_data", if_rdata[0], refm[0][8])

    // store to top address
    access(0, 1, 1, 10'h3FF, 32'hA5A5A5A5, 0);
    access(0, 1, 0, 10'h3FF, 32'h0, 0);

    // latency 4 fetch
    access(1, 0, 0, 10'h010, 32'h0, 0);

    // reset in the middle of a load's WAIT phase
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 10'h004;
    repeat (3) @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    `CHK("midreset_outputs", {mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1], if_valid[1], d_valid[1],
                              if_rdata[1], d_rdata[1]}, 108'd0)
    d_req[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    dcnt0 = dv_cnt[1]; ecnt0 = en_cnt[1];
    repeat (10) @(negedge clk);
    `CHK("midreset_no_valid", dv_cnt[1] - dcnt0, 0)
    `CHK("midreset_no_en", en_cnt[1] - ecnt0, 0)

    // continuous fetch stream on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 4; a++) begin
        last = en_cyc[d];
        access(d, 0, 0, 10'(a), 32'h0, a > 0);
        if (a > 0) `CHK("stream_spacing", en_cyc[d] - last, (d == 0 ? 1 : 4) + 3)
      end
      @(negedge clk);
    end

    // random mix of fetches, loads and stores over a small address window
    for (int i = 0; i < 60; i++) begin
      int d;
      bit isd, we;
      d = int'($urandom_range(1));
      isd = 1'($urandom_range(1));
      we = isd & 1'($urandom_range(1));
      access(d, isd, we, 10'($urandom_range(15)), $urandom, 0);
    end

    repeat (3) @(negedge clk);
    `CHK("protocol_violations", bad, 0)
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
It sequences each access through a fixed-latency memory and returns read data with a one-cycle valid pulse.
It drives a stall to the program counter and register-file write path while any access is outstanding.
It sits between the core and the unified memory, replacing the separate program and data memory ports.

Parameters:
ADDR_WIDTH, 10, word address width on all ports
DATA_WIDTH, 32, data width on all ports
MEM_LATENCY, 1, memory read latency in cycles after the enable edge; legal range 1..8

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
if_req_i  input  1  fetch request; held high until if_valid_o
if_addr_i  input  ADDR_WIDTH  fetch address; stable while if_req_i is high
if_rdata_o  output  DATA_WIDTH  fetched instruction; valid when if_valid_o
if_valid_o  output  1  one-cycle completion pulse for fetch
d_req_i  input  1  data request; held high until d_valid_o
d_we_i  input  1  1 = store, 0 = load
d_addr_i  input  ADDR_WIDTH  data address
d_wdata_i  input  DATA_WIDTH  store data
d_rdata_o  output  DATA_WIDTH  load data; valid when d_valid_o
d_valid_o  output  1  one-cycle completion pulse for data (loads and stores)
mem_en_o  output  1  memory enable, one-cycle pulse per access
mem_we_o  output  1  memory write enable; only high together with mem_en_o
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_rdata_i  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the enable cycle
core_stall_o  output  1  high while any request is pending and not yet completed

Behaviour:
- Reset: clk and rst_n as stated; reset is asynchronous and active-low.
- Reset values: state IDLE; mem_en_o, mem_we_o, if_valid_o, d_valid_o all 0; mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o all 0; latency counter 0.
- All outputs except core_stall_o are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: samples requests.
  - d_req_i has fixed priority over if_req_i.
  - The selected request's addr/we/wdata are latched into mem_* outputs, mem_en_o is set, and the owner (IF or D) is recorded; next state ACCESS.
  - No request: stay in IDLE.
- ACCESS: mem_en_o high for exactly this one cycle; the memory samples at the end of it.
  - Counter is loaded with MEM_LATENCY-1.
  - Next state: WAIT if MEM_LATENCY>1, otherwise capture in the following cycle.
- WAIT: counter decrements each cycle. In the cycle where mem_rdata_i is valid (MEM_LATENCY cycles after ACCESS):
  - mem_rdata_i is registered into the owner's rdata_o (loads and fetches only).
  - The owner's valid_o is set; next state RESP.
  - With MEM_LATENCY=1 the WAIT state lasts exactly one cycle.
- RESP: the owner's valid_o is high for exactly this cycle, then IDLE. Requests are ignored during RESP.
  - The requester may drop or change its req/addr at the edge ending RESP.
- Latency: request sampled in cycle C0 gives mem_en_o in C0+1 and valid_o in C0+MEM_LATENCY+2.
  - Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
- Stores: mem_we_o=1 with mem_en_o; d_valid_o pulses at the same time as for a load; d_rdata_o holds its previous value.
- Rdata outputs hold their last value until the next completion for that owner. if_valid_o and d_valid_o are never high together.
- Simultaneous if_req_i and d_req_i in IDLE: data is served first; fetch is served in the next IDLE.
- A request arriving while the other owner is in flight waits; there is no preemption.
- core_stall_o = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o), purely combinational. It is 0 in the valid cycle so the PC can advance.
- Reset mid-access: everything returns to reset values immediately; the in-flight memory response is discarded and no valid pulse is produced.

Test Plan:
1. Reset, MEM_LATENCY=1; if_req_i=1, if_addr_i=0x004, memory returns 0x00500093 → mem_en_o=1 with mem_addr_o=0x004 one cycle after the request; if_valid_o=1 and if_rdata_o=0x00500093 three cycles after the request; core_stall_o=1 until that cycle.
2. if_req_i and d_req_i both asserted in the same cycle (load at 0x100 returning 0xDEADBEEF, fetch at 0x008) → d_valid_o with 0xDEADBEEF first, then the fetch access; the second mem_en_o occurs exactly 4 cycles after the first; the valids never overlap.
3. Store with d_we_i=1, d_addr_i=0x3FF, d_wdata_i=0xA5A5A5A5 → a single cycle with mem_en_o=1, mem_we_o=1, mem_addr_o=0x3FF, mem_wdata_o=0xA5A5A5A5; d_valid_o pulses; d_rdata_o is unchanged.
4. MEM_LATENCY=4; fetch at 0x010 → the memory model checks that data is sampled 4 cycles after mem_en_o; if_valid_o arrives 6 cycles after the request; exactly one mem_en_o pulse.
5. rst_n dropped during WAIT of a load → all outputs go to 0 asynchronously; after release with no request, there is no d_valid_o and mem_en_o stays 0.
6. Continuous fetch stream to addresses 0, 1, 2, 3 (requester steps at each if_valid_o) → four accesses in order with correct data; no address is served twice; each mem_en_o is spaced MEM_LATENCY+3 cycles apart.
